// File: rtl/cache_pkg.sv
// Shared constants, state encoding and address-field helpers for the
// direct-mapped cache blocks.
package cache_pkg;

  localparam int ADDR_W  = 32;
  localparam int TAG_W   = 20;
  localparam int INDEX_W = 8;
  localparam int WOFF_W  = 2;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_FILL,
    S_TAG_WR,
    S_RESP
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-TAG_W-1 -: INDEX_W];
  endfunction

  function automatic logic [WOFF_W-1:0] addr_woff(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-TAG_W-INDEX_W-1 -: WOFF_W];
  endfunction

endpackage

// File: rtl/cache_refill_fsm.sv
// Request sequencer: tag lookup, hit check, word-by-word line refill,
// tag/valid update and a one-cycle completion pulse.
module cache_refill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W  = cache_pkg::ADDR_W,
  parameter int TAG_W   = cache_pkg::TAG_W,
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int WOFF_W  = cache_pkg::WOFF_W,
  parameter int DATA_W  = cache_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  output logic               lookup_valid,
  output logic [TAG_W-1:0]   lookup_tag,
  output logic [INDEX_W-1:0] lookup_index,
  input  logic               hit_flag,
  input  logic               line_valid,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               cache_we,
  output logic [INDEX_W-1:0] cache_windex,
  output logic [WOFF_W-1:0]  cache_wword,
  output logic [DATA_W-1:0]  cache_wdata,
  output logic               tag_we,
  output logic [TAG_W-1:0]   tag_wdata,
  output logic               resp_valid,
  output logic               resp_miss
);

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [WOFF_W-1:0]  cnt_q, cnt_d;
  logic               miss_q, miss_d;
  logic               fill;
  logic               unused_boff;

  // Word offset and byte offset of the request are irrelevant:
  // a miss always refills the whole line from word 0.
  assign unused_boff = ^req_addr[WOFF_W+1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          tag_d   = req_addr[ADDR_W-1 -: TAG_W];
          idx_d   = req_addr[ADDR_W-TAG_W-1 -: INDEX_W];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_CHECK;
      S_CHECK: begin
        miss_d  = !(hit_flag && line_valid);
        cnt_d   = '0;
        state_d = miss_d ? S_FILL : S_RESP;
      end
      S_FILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = S_TAG_WR;
        end
      end
      S_TAG_WR: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign fill         = (state_q == S_FILL);
  assign req_ready    = (state_q == S_IDLE);
  assign lookup_valid = (state_q == S_LOOKUP);
  assign lookup_tag   = tag_q;
  assign lookup_index = idx_q;

  assign mem_req  = fill;
  assign mem_addr = fill ? {tag_q, idx_q, cnt_q, 2'b00} : '0;

  // Only path from inputs to outputs: the ack writes the word straight in.
  assign cache_we     = fill && mem_ack;
  assign cache_windex = fill ? idx_q : '0;
  assign cache_wword  = fill ? cnt_q : '0;
  assign cache_wdata  = cache_we ? mem_rdata : '0;

  assign tag_we     = (state_q == S_TAG_WR);
  assign tag_wdata  = tag_we ? tag_q : '0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_miss  = resp_valid && miss_q;

endmodule
